// File: rtl/mpmc11_resp_burst_cnt.sv
// mpmc11_resp_burst_cnt
//   Response-side beat counter for one mpmc11 strip read transaction.
//   Counts returned read-data beats, tracks commands issued but not yet
//   answered, produces the strip-buffer write index, and reports completion
//   or protocol errors (unsolicited beat, outstanding overflow, timeout).
//
// Ports
//   rst           async active-high reset
//   clk           clock
//   abort         abandon transaction, clear counters/flags, go idle
//   arm           start a transaction (accepted in R_IDLE / R_DONE)
//   burst_len     expected beats minus one
//   req_fire      one read command accepted this cycle
//   rd_data_valid one read data beat returned this cycle
//   beat_we       strip-buffer write enable (combinational)
//   beat_idx      strip-buffer beat index (combinational)
//   resp_cnt      beats received so far
//   outstanding   commands accepted minus beats returned
//   busy          high while waiting for beats
//   done          one-cycle pulse with the final beat's count update
//   err_unsol     sticky unsolicited-beat error
//   err_ovf       sticky outstanding-overflow error
//   err_timeout   sticky timeout error
module mpmc11_resp_burst_cnt #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       abort,
  input  logic       arm,
  input  logic [5:0] burst_len,
  input  logic       req_fire,
  input  logic       rd_data_valid,
  output logic       beat_we,
  output logic [5:0] beat_idx,
  output logic [6:0] resp_cnt,
  output logic [6:0] outstanding,
  output logic       busy,
  output logic       done,
  output logic       err_unsol,
  output logic       err_ovf,
  output logic       err_timeout
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE, R_ERR} state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  state_t      state, state_n;
  logic [6:0]  resp_cnt_n, outstanding_n, exp_cnt, exp_cnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic [16:0] tcnt_inc;
  logic        done_n, err_unsol_n, err_ovf_n, err_timeout_n;
  logic        in_wait, unsol, ovf;

  assign in_wait  = (state == R_WAIT);
  assign busy     = in_wait;
  assign tcnt_inc = {1'b0, tcnt} + 17'd1;

  // A beat is only legitimate while waiting and with a command in flight
  // (a command accepted in the same cycle counts as in flight).
  assign unsol = rd_data_valid && (!in_wait || (outstanding == '0 && !req_fire));
  assign ovf   = req_fire && !rd_data_valid && (outstanding == 7'd64);

  assign beat_we  = in_wait && !abort && rd_data_valid && (outstanding != '0 || req_fire);
  assign beat_idx = resp_cnt[5:0];

  always_comb begin
    state_n       = state;
    resp_cnt_n    = resp_cnt;
    outstanding_n = outstanding;
    exp_cnt_n     = exp_cnt;
    tcnt_n        = tcnt;
    done_n        = 1'b0;
    err_unsol_n   = err_unsol;
    err_ovf_n     = err_ovf;
    err_timeout_n = err_timeout;

    if (abort) begin
      state_n       = R_IDLE;
      resp_cnt_n    = '0;
      outstanding_n = '0;
      tcnt_n        = '0;
      err_unsol_n   = 1'b0;
      err_ovf_n     = 1'b0;
      err_timeout_n = 1'b0;
    end else if (state != R_ERR) begin
      if (unsol || ovf) begin
        // Counters hold; overflow leaves outstanding saturated at 64.
        state_n     = R_ERR;
        err_unsol_n = err_unsol | unsol;
        err_ovf_n   = err_ovf | ovf;
      end else if (arm && !in_wait) begin
        state_n       = R_WAIT;
        exp_cnt_n     = {1'b0, burst_len} + 7'd1;
        resp_cnt_n    = '0;
        outstanding_n = req_fire ? 7'd1 : 7'd0;
        tcnt_n        = '0;
      end else if (in_wait) begin
        case ({req_fire, rd_data_valid})
          2'b10:   outstanding_n = outstanding + 7'd1;
          2'b01:   outstanding_n = outstanding - 7'd1;
          default: outstanding_n = outstanding;
        endcase
        if (rd_data_valid) begin
          resp_cnt_n = resp_cnt + 7'd1;
          if (resp_cnt_n == exp_cnt) begin
            done_n  = 1'b1;
            state_n = R_DONE;
          end
        end
        if (req_fire || rd_data_valid) begin
          tcnt_n = '0;
        end else begin
          tcnt_n = tcnt_inc[15:0];
          if (tcnt_inc == TIMEOUT_W) begin
            err_timeout_n = 1'b1;
            state_n       = R_ERR;
          end
        end
      end else if (req_fire) begin
        // Prefetch ahead of arm in R_IDLE / R_DONE.
        outstanding_n = outstanding + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= R_IDLE;
      resp_cnt    <= '0;
      outstanding <= '0;
      exp_cnt     <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      err_unsol   <= 1'b0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      resp_cnt    <= resp_cnt_n;
      outstanding <= outstanding_n;
      exp_cnt     <= exp_cnt_n;
      tcnt        <= tcnt_n;
      done        <= done_n;
      err_unsol   <= err_unsol_n;
      err_ovf     <= err_ovf_n;
      err_timeout <= err_timeout_n;
    end
  end

endmodule

// File: tb/tb_mpmc11_resp_burst_cnt.sv
// Testbench for mpmc11_resp_burst_cnt: directed stimulus pushes expected
// beat indices and done counts into queues; a negedge monitor pops and
// compares whenever the DUT writes a beat or pulses done.
module tb_mpmc11_resp_burst_cnt;

  logic       rst, clk, abort, arm, req_fire, rd_data_valid;
  logic [5:0] burst_len;
  logic       beat_we, busy, done, err_unsol, err_ovf, err_timeout;
  logic [5:0] beat_idx;
  logic [6:0] resp_cnt, outstanding;

  int n_checks = 0;
  int n_fail   = 0;
  int beat_q[$];
  int done_q[$];

  mpmc11_resp_burst_cnt #(.TIMEOUT(16)) dut (
    .rst(rst), .clk(clk), .abort(abort), .arm(arm), .burst_len(burst_len),
    .req_fire(req_fire), .rd_data_valid(rd_data_valid), .beat_we(beat_we),
    .beat_idx(beat_idx), .resp_cnt(resp_cnt), .outstanding(outstanding),
    .busy(busy), .done(done), .err_unsol(err_unsol), .err_ovf(err_ovf),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic step(input logic a, input logic [5:0] bl, input logic rf,
                      input logic rv, input logic ab);
    arm = a; burst_len = bl; req_fire = rf; rd_data_valid = rv; abort = ab;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (beat_we) begin
      if (beat_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat: got beat_we=1 idx=%0d expected no beat (t=%0t)", beat_idx, $time);
      end else begin
        check("beat_idx", 32'(beat_idx), 32'(beat_q.pop_front()));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
      end else begin
        check("done_resp_cnt", 32'(resp_cnt), 32'(done_q.pop_front()));
      end
    end
  end

  initial begin
    int bcnt;
    rst = 1'b1; abort = 0; arm = 0; burst_len = 0; req_fire = 0; rd_data_valid = 0;
    @(posedge clk); #1;
    check("rst_resp_cnt", 32'(resp_cnt), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_errs", 32'({err_unsol, err_ovf, err_timeout}), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst of 4
    step(1, 6'd3, 0, 0, 0);
    check("basic_busy", 32'(busy), 1);
    repeat (4) step(0, 0, 1, 0, 0);
    check("basic_outst4", 32'(outstanding), 4);
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back(i);
      if (i == 3) done_q.push_back(4);
      step(0, 0, 0, 1, 0);
      if (i == 3) check("basic_done", 32'(done), 1);
    end
    check("basic_resp_cnt", 32'(resp_cnt), 4);
    check("basic_outst0", 32'(outstanding), 0);
    check("basic_busy_end", 32'(busy), 0);
    idle();
    check("basic_done_pulse", 32'(done), 0);

    // Overlap: 64 beats, requests lead by 5
    bcnt = 0;
    for (int c = 0; c <= 68; c++) begin
      if (c >= 5) begin
        beat_q.push_back(bcnt);
        bcnt++;
        if (bcnt == 64) done_q.push_back(64);
      end
      step(c == 0, 6'd63, c <= 63, c >= 5, 0);
      if (c == 20) check("ovl_plateau", 32'(outstanding), 5);
    end
    check("ovl_resp_cnt", 32'(resp_cnt), 64);
    check("ovl_outst", 32'(outstanding), 0);
    check("ovl_errs", 32'({err_unsol, err_ovf, err_timeout}), 0);
    check("ovl_busy", 32'(busy), 0);
    idle();

    // Unsolicited beat
    step(1, 6'd1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("unsol_flag", 32'(err_unsol), 1);
    check("unsol_busy", 32'(busy), 0);
    check("unsol_resp_cnt", 32'(resp_cnt), 0);
    step(0, 0, 0, 1, 0);
    check("unsol_frozen", 32'(resp_cnt), 0);
    step(0, 0, 0, 0, 1);
    check("unsol_abort_flag", 32'(err_unsol), 0);
    check("unsol_abort_busy", 32'(busy), 0);

    // Timeout (TIMEOUT=16)
    step(1, 6'd0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("to_outst", 32'(outstanding), 1);
    repeat (15) idle();
    check("to_not_yet", 32'(err_timeout), 0);
    check("to_busy_before", 32'(busy), 1);
    idle();
    check("to_flag", 32'(err_timeout), 1);
    check("to_busy_after", 32'(busy), 0);
    step(0, 0, 0, 0, 1);
    check("to_abort", 32'(err_timeout), 0);

    // Abort mid-burst
    step(1, 6'd7, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      beat_q.push_back(i);
      step(0, 0, 0, 1, 0);
    end
    check("abort_pre_cnt", 32'(resp_cnt), 3);
    step(0, 0, 0, 0, 1);
    check("abort_resp_cnt", 32'(resp_cnt), 0);
    check("abort_busy", 32'(busy), 0);

    // Async reset mid-burst
    step(1, 6'd7, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    beat_q.push_back(0);
    step(0, 0, 0, 1, 0);
    check("arst_pre_cnt", 32'(resp_cnt), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_resp_cnt", 32'(resp_cnt), 0);
    check("arst_outst", 32'(outstanding), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_beat_we", 32'(beat_we), 0);
    arm = 0; req_fire = 0; rd_data_valid = 0; abort = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Overflow
    step(1, 6'd63, 1, 0, 0);
    repeat (63) step(0, 0, 1, 0, 0);
    check("ovf_outst64", 32'(outstanding), 64);
    check("ovf_not_yet", 32'(err_ovf), 0);
    step(0, 0, 1, 0, 0);
    check("ovf_flag", 32'(err_ovf), 1);
    check("ovf_sat", 32'(outstanding), 64);
    check("ovf_busy", 32'(busy), 0);
    step(0, 0, 0, 0, 1);

    // Prefetch in idle, cleared by arm; beat coincident with arm
    step(0, 0, 1, 0, 0);
    check("pref_outst", 32'(outstanding), 1);
    check("pref_noerr", 32'({err_unsol, err_ovf, err_timeout}), 0);
    step(1, 6'd2, 0, 0, 0);
    check("pref_cleared", 32'(outstanding), 0);
    step(0, 0, 0, 0, 1);
    step(1, 6'd2, 0, 1, 0);
    check("arm_beat_unsol", 32'(err_unsol), 1);
    step(0, 0, 0, 0, 1);

    idle();
    check("beat_q_empty", 32'(beat_q.size()), 0);
    check("done_q_empty", 32'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpmc11_resp_burst_cnt.md
Name: mpmc11_resp_burst_cnt

Overview:
- Response-side companion to the mpmc11 request burst counter.
- Counts read-data beats returned by the memory interface (app_rd_data_valid) for the current strip transaction.
- Tracks read commands that are issued but not yet answered, and generates the write index into the read strip buffer.
- Signals completion, or flags a protocol error (unsolicited beat, outstanding overflow, timeout) to the mpmc11 controller state machine.

Parameters:
TIMEOUT, 1023, number of idle cycles in R_WAIT with no beat and no req_fire before err_timeout is set; legal range 1..65535.

Ports:
rst  input  1  asynchronous reset, active-high
clk  input  1  clock
abort  input  1  controller abandons transaction; clears counters, returns to R_IDLE
arm  input  1  pulse; start of a read transaction; latches burst_len
burst_len  input  6  beats minus one (expected beats = burst_len+1, 1..64)
req_fire  input  1  one read command accepted by memory interface this cycle (app_en & app_rdy)
rd_data_valid  input  1  one read data beat returned this cycle
beat_we  output  1  strip-buffer write enable for this beat
beat_idx  output  6  strip-buffer beat index for this beat
resp_cnt  output  7  beats received in current transaction (0..64)
outstanding  output  7  commands accepted minus beats returned (0..64)
busy  output  1  high in R_WAIT
done  output  1  one-cycle pulse on final beat
err_unsol  output  1  sticky: beat with outstanding==0, or beat outside R_WAIT
err_ovf  output  1  sticky: req_fire while outstanding==64
err_timeout  output  1  sticky: TIMEOUT expired in R_WAIT

Behaviour:
- Reset (async, rst=1): state=R_IDLE; all counters, the latched expected count, the timeout counter and all outputs are 0.
- States: R_IDLE, R_WAIT, R_DONE, R_ERR. busy = (state==R_WAIT).
- Priority each cycle: abort > error detection > arm > normal counting.
- abort, any state:
  - next state R_IDLE.
  - resp_cnt, outstanding and timeout counter cleared; err_* flags cleared.
  - any beat or req_fire in the same cycle is ignored.
- arm:
  - Accepted only in R_IDLE or R_DONE; ignored in R_WAIT and R_ERR.
  - On accept: exp = {1'b0,burst_len}+7'd1; resp_cnt=0; outstanding=0; timeout counter=0; next R_WAIT.
  - A req_fire coincident with arm is counted (outstanding=1 next cycle).
  - A rd_data_valid coincident with arm is an unsolicited beat.
- R_WAIT, normal counting:
  - req_fire alone: outstanding+1. rd_data_valid alone: outstanding-1. Both in the same cycle: outstanding unchanged.
  - On rd_data_valid with (outstanding>0 or req_fire):
    - beat_we=1 combinationally; beat_idx=resp_cnt[5:0] (value before increment); resp_cnt+1 registered.
  - When the incremented resp_cnt equals exp:
    - done=1 for one cycle, registered coincident with the resp_cnt update; next R_DONE.
    - outstanding keeps its computed value; a non-zero value is left for the controller to inspect.
  - Timeout counter: cleared on any req_fire or rd_data_valid, else +1. Reaching TIMEOUT sets err_timeout; next R_ERR.
- Error detection (any state except R_ERR):
  - rd_data_valid with outstanding==0 and no coincident req_fire, or rd_data_valid in R_IDLE/R_DONE:
    - err_unsol=1; beat_we=0; resp_cnt unchanged; next R_ERR.
  - req_fire with outstanding==64 (and no coincident beat): err_ovf=1; outstanding saturates at 64; next R_ERR.
  - req_fire in R_IDLE/R_DONE: outstanding+1 with no error, allowing a prefetch ahead of arm. It is cleared by the next arm unless it coincides with arm.
- R_ERR:
  - Counters frozen; beat_we=0; further beats ignored.
  - Exits only via abort or rst.
- beat_we is asserted only in R_WAIT. done never asserts in the same cycle as any err_* set.
- No wrap-around: resp_cnt cannot exceed exp, because reaching exp leaves R_WAIT.

Test Plan:
- Basic burst: rst, arm burst_len=3, 4 req_fire then 4 rd_data_valid -> beat_idx 0,1,2,3 with beat_we each beat; done pulse on 4th beat; resp_cnt=4, outstanding=0, state R_DONE.
- Overlap: burst_len=63, req_fire every cycle, rd_data_valid starting 5 cycles later and concurrent -> outstanding plateaus at 5; done after 64th beat; beat_idx runs 0..63; no errors.
- Unsolicited: arm burst_len=1, rd_data_valid before any req_fire -> err_unsol=1, beat_we=0, R_ERR; extra beats ignored; abort -> R_IDLE, flags 0.
- Timeout: TIMEOUT=16, arm, 1 req_fire, no beats -> err_timeout set exactly 16 cycles after the req_fire; busy drops.
- Abort/reset mid-burst: burst_len=7, 3 beats received, then abort -> resp_cnt=0, R_IDLE. Repeat with rst asserted asynchronously mid-cycle -> all outputs 0 immediately.
- Overflow: arm burst_len=63, 65 req_fire with no beats -> err_ovf on 65th, outstanding=64.
